pci_initiator_ctrl: RTL and testbench
=====================================

Name: pci_initiator_ctrl

Overview:
- PCI initiator (master) transaction sequencer for the PCI bus interface.
- Accepts a local burst request, arbitrates with REQ#/GNT#, then drives the address phase and counts data phases.
- Drives the data-phase handshake on FRAME#/IRDY#, C/BE# and AD, and feeds our byte-enable stage with irdy_n, cbe, rw and AD.
- Returns read data and completion/abort status to the local side.

Parameters:
- DEVSEL_TIMEOUT, 5, clocks after the address phase without devsel_n low before master abort.
- CMD_READ, 4'b0110, C/BE# command driven in the address phase for reads (memory read).
- CMD_WRITE, 4'b0111, C/BE# command driven in the address phase for writes (memory write).

Ports:
- clk  in  1  bus clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request pulse; sampled only in IDLE.
- rw  in  1  0 = read, 1 = write; latched on start.
- addr  in  32  start address; latched on start.
- data_num  in  4  number of data phases, 1..15; latched on start.
- be  in  4  active-high byte enables for every data phase; latched on start.
- wr_data  in  32  write word from the local buffer; valid whenever busy.
- gnt_n  in  1  bus grant, active low.
- devsel_n  in  1  target device select, active low.
- trdy_n  in  1  target ready, active low.
- req_n  out  1  bus request, active low.
- frame_n  out  1  FRAME#, active low.
- irdy_n  out  1  IRDY#, active low.
- cbe  out  4  command in the address phase; active-high byte enables in data phases.
- ad_out  out  32  AD drive value.
- ad_oe  out  1  AD output enable.
- wr_pop  out  1  advances the local write buffer.
- rd_data  out  32  captured read word.
- rd_valid  out  1  1-cycle strobe qualifying rd_data.
- busy  out  1  high from start until the return to IDLE.
- done  out  1  1-cycle strobe on normal completion.
- abort  out  1  1-cycle strobe on master abort.

Behaviour:
- Reset values:
  - req_n, frame_n, irdy_n = 1.
  - cbe = 0, ad_out = 0, ad_oe = 0.
  - wr_pop, rd_valid, busy, done, abort = 0.
  - rd_data = 0; state = IDLE.
- Reset is asynchronous and can occur in any state. It aborts the transaction immediately to the reset values, with no done or abort strobe.
- All outputs are registered.
- States: IDLE, REQ, ADDR, TURN, DATA, ABORT, END.
- IDLE:
  - start with data_num != 0: latch the inputs, set remaining = data_num, busy = 1, req_n = 0, go to REQ.
  - start with data_num == 0: ignored, no output change.
- REQ: wait while gnt_n == 1. When gnt_n == 0 is sampled, go to ADDR with:
  - frame_n = 0, ad_out = addr, ad_oe = 1, cbe = command.
  - req_n = 1.
- ADDR: exactly one cycle.
  - Read: go to TURN; ad_oe = 0 and irdy_n = 0 from the TURN cycle.
  - Write: go to DATA; ad_out = wr_data, ad_oe = 1, irdy_n = 0.
  - Either way cbe = be, and the devsel counter starts at 0.
- TURN: one cycle, then go to DATA.
- DATA, transfer condition: a transfer occurs on any cycle where irdy_n == 0 and trdy_n == 0 are sampled. Wait states (trdy_n == 1) hold all outputs.
- On each transfer:
  - remaining decrements.
  - Write: wr_pop pulses for one cycle; the next word is driven on ad_out in the following cycle.
  - Read: rd_data is loaded from the AD input and rd_valid pulses in the same registered cycle.
- frame_n rule: frame_n = 1 during the final data phase. For data_num == 1 this is the first DATA cycle. Otherwise frame_n goes high on the cycle after the transfer that leaves remaining == 1. irdy_n stays 0 throughout.
- Final transfer (remaining 1 to 0) → END with:
  - irdy_n = 1, ad_oe = 0, cbe = 0.
- Devsel timeout: if devsel_n has not been sampled low within DEVSEL_TIMEOUT cycles after ADDR, go to ABORT. No further transfers are counted.
- ABORT: one cycle with frame_n = 1 and irdy_n = 0, then go to END. abort is strobed on entry to END; done is not.
- END: one cycle.
  - busy = 0.
  - done = 1, unless the path came through ABORT.
  - Go to IDLE.
- start outside IDLE is ignored.
- remaining is 4-bit with no wrap. Count 15 is legal, and remaining never decrements below 0.

Test Plan:
- Write, data_num = 3, be = 1111, gnt_n low at cycle 2, trdy_n always low → frame_n low for 3 cycles (ADDR plus 2 data phases) and high during the 3rd; 3 wr_pop pulses; done on the cycle after the last transfer; busy drops the same cycle.
- Read, data_num = 1, be = 0011, AD input = 0xA5A5_1234 → TURN cycle with ad_oe = 0; frame_n high in the first DATA cycle; rd_valid with rd_data = 0xA5A5_1234; done.
- Write, data_num = 2, trdy_n high for 2 cycles in each data phase → outputs held during the waits; exactly 2 wr_pop pulses; frame_n high only after the first transfer.
- devsel_n held high after ADDR → ABORT after 5 cycles; abort = 1, done = 0; no wr_pop or rd_valid; bus lines return to 1.
- rst_n low during DATA of a 4-phase burst → all outputs at reset values immediately (asynchronously); no strobes; a fresh start is accepted afterwards.
- start with data_num = 0, and start while busy → no bus activity and no strobes in both cases.

Source files
------------

// File: rtl/pci_initiator_ctrl_if.sv
// PCI bus-side signal bundle for the initiator sequencer.
// master: the initiator drives REQ#/FRAME#/IRDY#/C/BE#/AD and samples GNT#/DEVSEL#/TRDY#/AD.
// slave:  the arbiter/target side of the same wires.
interface pci_initiator_ctrl_if;
  logic        gnt_n;
  logic        devsel_n;
  logic        trdy_n;
  logic [31:0] ad_in;
  logic        req_n;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe;
  logic [31:0] ad_out;
  logic        ad_oe;

  modport master (
    input  gnt_n, devsel_n, trdy_n, ad_in,
    output req_n, frame_n, irdy_n, cbe, ad_out, ad_oe
  );

  modport slave (
    output gnt_n, devsel_n, trdy_n, ad_in,
    input  req_n, frame_n, irdy_n, cbe, ad_out, ad_oe
  );
endinterface

// File: rtl/pci_initiator_ctrl.sv
// PCI initiator transaction sequencer: arbitrates for the bus, drives the
// address phase, counts data phases and reports completion or master abort.
// Every output comes straight from a flop; the output process computes the
// next value of each output register alongside the next state.
module pci_initiator_ctrl #(
  parameter int         DEVSEL_TIMEOUT = 5,
  parameter logic [3:0] CMD_READ       = 4'b0110,
  parameter logic [3:0] CMD_WRITE      = 4'b0111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     rw,
  input  logic [31:0]              addr,
  input  logic [3:0]               data_num,
  input  logic [3:0]               be,
  input  logic [31:0]              wr_data,
  pci_initiator_ctrl_if.master     bus,
  output logic                     wr_pop,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     abort
);

  localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_TURN, S_DATA, S_ABORT, S_END
  } state_t;

  state_t r_state, w_state_nxt;

  // Latched request and transaction bookkeeping
  logic             r_rw, w_rw;
  logic [31:0]      r_addr, w_addr;
  logic [3:0]       r_be, w_be;
  logic [3:0]       r_rem, w_rem;
  logic [CNT_W-1:0] r_dcnt, w_dcnt;
  logic             r_dev_seen, w_dev_seen;

  // Output registers and their next values
  logic        r_req_n, w_req_n;
  logic        r_frame_n, w_frame_n;
  logic        r_irdy_n, w_irdy_n;
  logic [3:0]  r_cbe, w_cbe;
  logic [31:0] r_ad_out, w_ad_out;
  logic        r_ad_oe, w_ad_oe;
  logic        r_wr_pop, w_wr_pop;
  logic [31:0] r_rd_data, w_rd_data;
  logic        r_rd_valid, w_rd_valid;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_abort, w_abort;

  // DEVSEL# is tracked from the cycle after ADDR; a transfer needs IRDY# and TRDY# both low.
  logic w_on_bus, w_dev_ok, w_timeout, w_xfer, w_last;
  assign w_on_bus  = (r_state == S_TURN) || (r_state == S_DATA);
  assign w_dev_ok  = r_dev_seen || !bus.devsel_n;
  assign w_timeout = w_on_bus && !w_dev_ok && (r_dcnt == CNT_W'(DEVSEL_TIMEOUT - 1));
  assign w_xfer    = (r_state == S_DATA) && !r_irdy_n && !bus.trdy_n && !w_timeout;
  assign w_last    = w_xfer && (r_rem == 4'd1);

  // State and every registered output/bookkeeping value, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_rem      <= '0;
      r_dcnt     <= '0;
      r_dev_seen <= 1'b0;
      r_req_n    <= 1'b1;
      r_frame_n  <= 1'b1;
      r_irdy_n   <= 1'b1;
      r_cbe      <= '0;
      r_ad_out   <= '0;
      r_ad_oe    <= 1'b0;
      r_wr_pop   <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rw       <= w_rw;
      r_addr     <= w_addr;
      r_be       <= w_be;
      r_rem      <= w_rem;
      r_dcnt     <= w_dcnt;
      r_dev_seen <= w_dev_seen;
      r_req_n    <= w_req_n;
      r_frame_n  <= w_frame_n;
      r_irdy_n   <= w_irdy_n;
      r_cbe      <= w_cbe;
      r_ad_out   <= w_ad_out;
      r_ad_oe    <= w_ad_oe;
      r_wr_pop   <= w_wr_pop;
      r_rd_data  <= w_rd_data;
      r_rd_valid <= w_rd_valid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_abort    <= w_abort;
    end
  end

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && (data_num != 4'd0)) w_state_nxt = S_REQ;
      S_REQ:   if (!bus.gnt_n) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = r_rw ? S_DATA : S_TURN;
      S_TURN:  w_state_nxt = w_timeout ? S_ABORT : S_DATA;
      S_DATA:  if (w_timeout) w_state_nxt = S_ABORT;
               else if (w_last) w_state_nxt = S_END;
      S_ABORT: w_state_nxt = S_END;
      S_END:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of outputs and bookkeeping; anything not assigned holds (wait states)
  always_comb begin
    w_rw       = r_rw;
    w_addr     = r_addr;
    w_be       = r_be;
    w_rem      = r_rem;
    w_dcnt     = r_dcnt;
    w_dev_seen = r_dev_seen;
    w_req_n    = r_req_n;
    w_frame_n  = r_frame_n;
    w_irdy_n   = r_irdy_n;
    w_cbe      = r_cbe;
    w_ad_out   = r_ad_out;
    w_ad_oe    = r_ad_oe;
    w_rd_data  = r_rd_data;
    w_busy     = r_busy;
    w_wr_pop   = 1'b0;
    w_rd_valid = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;

    if (w_on_bus) begin
      w_dev_seen = w_dev_ok;
      if (!w_dev_ok) w_dcnt = r_dcnt + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (start && (data_num != 4'd0)) begin
          w_rw    = rw;
          w_addr  = addr;
          w_be    = be;
          w_rem   = data_num;
          w_busy  = 1'b1;
          w_req_n = 1'b0;
        end
      end
      S_REQ: begin
        if (!bus.gnt_n) begin
          w_frame_n = 1'b0;
          w_ad_out  = r_addr;
          w_ad_oe   = 1'b1;
          w_cbe     = r_rw ? CMD_WRITE : CMD_READ;
          w_req_n   = 1'b1;
        end
      end
      S_ADDR: begin
        w_cbe      = r_be;
        w_irdy_n   = 1'b0;
        w_dcnt     = '0;
        w_dev_seen = 1'b0;
        if (r_rw) begin
          w_ad_out = wr_data;
          w_ad_oe  = 1'b1;
          // single-phase write: the first data phase is already the last one
          if (r_rem == 4'd1) w_frame_n = 1'b1;
        end else begin
          w_ad_oe = 1'b0;
        end
      end
      S_TURN: begin
        if (w_timeout) begin
          w_frame_n = 1'b1;
          w_ad_oe   = 1'b0;
        end else if (r_rem == 4'd1) begin
          w_frame_n = 1'b1;
        end
      end
      S_DATA: begin
        if (w_timeout) begin
          w_frame_n = 1'b1;
          w_ad_oe   = 1'b0;
        end else if (w_xfer) begin
          if (r_rem != 4'd0) w_rem = r_rem - 4'd1;
          if (r_rw) begin
            w_wr_pop = 1'b1;
            if (!w_last) w_ad_out = wr_data;
          end else begin
            w_rd_data  = bus.ad_in;
            w_rd_valid = 1'b1;
          end
          if (w_last) begin
            w_frame_n = 1'b1;
            w_irdy_n  = 1'b1;
            w_ad_oe   = 1'b0;
            w_cbe     = '0;
            w_busy    = 1'b0;
            w_done    = 1'b1;
          end else if (r_rem == 4'd2) begin
            w_frame_n = 1'b1;
          end
        end
      end
      S_ABORT: begin
        w_frame_n = 1'b1;
        w_irdy_n  = 1'b1;
        w_ad_oe   = 1'b0;
        w_cbe     = '0;
        w_busy    = 1'b0;
        w_abort   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.req_n   = r_req_n;
  assign bus.frame_n = r_frame_n;
  assign bus.irdy_n  = r_irdy_n;
  assign bus.cbe     = r_cbe;
  assign bus.ad_out  = r_ad_out;
  assign bus.ad_oe   = r_ad_oe;
  assign wr_pop      = r_wr_pop;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign abort       = r_abort;

endmodule

// File: tb/tb_pci_initiator_ctrl.sv
// Directed bench for pci_initiator_ctrl: the stimulus process plays the local
// side and the bus target, pushes expected local-side strobes into a queue,
// and a negedge monitor pops and compares each strobe the DUT raises.
module tb_pci_initiator_ctrl;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_DONE = 2'd2, K_ABT = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, rw;
  logic [31:0] addr, wr_data;
  logic [3:0]  data_num, be;
  logic        wr_pop, rd_valid, busy, done, abort;
  logic [31:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] sbq[$];

  pci_initiator_ctrl_if bus ();

  pci_initiator_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr),
    .data_num(data_num), .be(be), .wr_data(wr_data), .bus(bus),
    .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_take(input logic [1:0] k, input logic [31:0] d, input string nm);
    logic [33:0] e;
    n_tests++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL sb_%s: got unexpected strobe data %h, expected no strobe", nm, d);
    end else begin
      e = sbq.pop_front();
      if (e !== {k, d}) begin
        n_fail++;
        $display("FAIL sb_%s: got kind %0d data %h expected kind %0d data %h",
                 nm, k, d, e[33:32], e[31:0]);
      end
    end
  endtask

  // Monitor: data strobes first, then completion, matching push order
  always @(negedge clk) begin
    if (rd_valid) sb_take(K_RD, rd_data, "rd");
    if (wr_pop)   sb_take(K_WR, 32'h0, "wrpop");
    if (done)     sb_take(K_DONE, 32'h0, "done");
    if (abort)    sb_take(K_ABT, 32'h0, "abort");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [31:0] d);
    sbq.push_back({k, d});
  endtask

  task automatic start_txn(input logic r, input logic [31:0] a, input logic [3:0] n,
                           input logic [3:0] b, input logic [31:0] wd);
    start = 1'b1; rw = r; addr = a; data_num = n; be = b; wr_data = wd;
    tick();
    start = 1'b0;
  endtask

  task automatic grant();
    bus.gnt_n = 1'b0;
    tick();
    bus.gnt_n = 1'b1;
  endtask

  task automatic bus_idle();
    bus.devsel_n = 1'b1; bus.trdy_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_n"},   bus.req_n,   1);
    chk({tag, "_frame_n"}, bus.frame_n, 1);
    chk({tag, "_irdy_n"},  bus.irdy_n,  1);
    chk({tag, "_cbe"},     bus.cbe,     0);
    chk({tag, "_ad_out"},  bus.ad_out,  0);
    chk({tag, "_ad_oe"},   bus.ad_oe,   0);
    chk({tag, "_wr_pop"},  wr_pop,      0);
    chk({tag, "_rd_valid"}, rd_valid,   0);
    chk({tag, "_rd_data"}, rd_data,     0);
    chk({tag, "_busy"},    busy,        0);
    chk({tag, "_done"},    done,        0);
    chk({tag, "_abort"},   abort,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; data_num = '0; be = '0; wr_data = '0;
    bus.gnt_n = 1'b1; bus.ad_in = '0; bus_idle();
    tick(); tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Write burst of 3, no wait states
    repeat (3) push(K_WR, 0);
    push(K_DONE, 0);
    start_txn(1'b1, 32'h1000_0000, 4'd3, 4'hF, 32'hDEAD_0001);
    chk("w3_req_n", bus.req_n, 0);
    chk("w3_busy", busy, 1);
    tick();
    chk("w3_req_hold", bus.req_n, 0);
    grant();
    chk("w3_addr_frame", bus.frame_n, 0);
    chk("w3_addr_oe", bus.ad_oe, 1);
    chk("w3_addr_ad", bus.ad_out, 32'h1000_0000);
    chk("w3_addr_cmd", bus.cbe, 4'b0111);
    chk("w3_addr_req", bus.req_n, 1);
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0;
    tick();
    chk("w3_d1_frame", bus.frame_n, 0);
    chk("w3_d1_irdy", bus.irdy_n, 0);
    chk("w3_d1_cbe", bus.cbe, 4'hF);
    chk("w3_d1_ad", bus.ad_out, 32'hDEAD_0001);
    tick();
    chk("w3_d2_frame", bus.frame_n, 0);
    tick();
    chk("w3_d3_frame", bus.frame_n, 1);
    chk("w3_d3_irdy", bus.irdy_n, 0);
    tick();
    chk("w3_end_busy", busy, 0);
    chk("w3_end_irdy", bus.irdy_n, 1);
    chk("w3_end_oe", bus.ad_oe, 0);
    chk("w3_end_cbe", bus.cbe, 0);
    bus_idle();
    tick();

    // Single-phase read
    push(K_RD, 32'hA5A5_1234);
    push(K_DONE, 0);
    start_txn(1'b0, 32'h2000_0040, 4'd1, 4'b0011, 32'h0);
    grant();
    chk("r1_addr_cmd", bus.cbe, 4'b0110);
    chk("r1_addr_ad", bus.ad_out, 32'h2000_0040);
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0; bus.ad_in = 32'hA5A5_1234;
    tick();
    chk("r1_turn_oe", bus.ad_oe, 0);
    chk("r1_turn_irdy", bus.irdy_n, 0);
    chk("r1_turn_frame", bus.frame_n, 0);
    chk("r1_turn_cbe", bus.cbe, 4'b0011);
    tick();
    chk("r1_data_frame", bus.frame_n, 1);
    chk("r1_data_irdy", bus.irdy_n, 0);
    tick();
    chk("r1_end_busy", busy, 0);
    chk("r1_end_irdy", bus.irdy_n, 1);
    bus_idle();
    tick();

    // Write of 2 with two wait states in each data phase
    repeat (2) push(K_WR, 0);
    push(K_DONE, 0);
    start_txn(1'b1, 32'h3000_0000, 4'd2, 4'hC, 32'h0000_BEEF);
    grant();
    bus.devsel_n = 1'b0;
    tick();
    chk("w2_w1_frame", bus.frame_n, 0);
    tick();
    chk("w2_w2_frame", bus.frame_n, 0);
    chk("w2_w2_irdy", bus.irdy_n, 0);
    chk("w2_w2_ad", bus.ad_out, 32'h0000_BEEF);
    chk("w2_w2_oe", bus.ad_oe, 1);
    bus.trdy_n = 1'b0;
    tick();
    bus.trdy_n = 1'b1;
    chk("w2_d2_frame", bus.frame_n, 1);
    chk("w2_d2_irdy", bus.irdy_n, 0);
    tick();
    chk("w2_d2w_frame", bus.frame_n, 1);
    chk("w2_d2w_busy", busy, 1);
    tick();
    bus.trdy_n = 1'b0;
    tick();
    chk("w2_end_busy", busy, 0);
    bus_idle();
    tick();

    // Master abort: DEVSEL# never asserted
    push(K_ABT, 0);
    start_txn(1'b1, 32'h4000_0000, 4'd4, 4'hF, 32'h1111_2222);
    grant();
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("ab_d%0d_frame", i), bus.frame_n, 0);
      chk($sformatf("ab_d%0d_irdy", i), bus.irdy_n, 0);
    end
    tick();
    chk("ab_abort_frame", bus.frame_n, 1);
    chk("ab_abort_irdy", bus.irdy_n, 0);
    tick();
    chk("ab_end_irdy", bus.irdy_n, 1);
    chk("ab_end_frame", bus.frame_n, 1);
    chk("ab_end_req", bus.req_n, 1);
    chk("ab_end_oe", bus.ad_oe, 0);
    chk("ab_end_busy", busy, 0);
    chk("ab_end_done", done, 0);
    tick();

    // Asynchronous reset in the middle of a 4-phase write
    repeat (2) push(K_WR, 0);
    start_txn(1'b1, 32'h5000_0000, 4'd4, 4'hF, 32'h5555_AAAA);
    grant();
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    bus_idle();
    tick(); tick();
    chk("arst_hold_busy", busy, 0);
    chk("arst_hold_frame", bus.frame_n, 1);
    rst_n = 1'b1;
    tick();
    push(K_RD, 32'h0BAD_F00D);
    push(K_DONE, 0);
    start_txn(1'b0, 32'h6000_0000, 4'd1, 4'hF, 32'h0);
    chk("arst_fresh_busy", busy, 1);
    grant();
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0; bus.ad_in = 32'h0BAD_F00D;
    tick(); tick(); tick();
    chk("arst_fresh_end", busy, 0);
    bus_idle();
    tick();

    // Ignored starts: zero length, and a start while busy
    start = 1'b1; rw = 1'b1; data_num = 4'd0; addr = 32'h7000_0000;
    tick();
    start = 1'b0;
    tick();
    chk("z_req_n", bus.req_n, 1);
    chk("z_busy", busy, 0);
    push(K_RD, 32'h1357_9BDF);
    push(K_DONE, 0);
    start_txn(1'b0, 32'h3000_0000, 4'd1, 4'hF, 32'h0);
    start = 1'b1; rw = 1'b1; addr = 32'hFFFF_0000; data_num = 4'd5;
    tick();
    start = 1'b0;
    grant();
    chk("bz_cmd", bus.cbe, 4'b0110);
    chk("bz_ad", bus.ad_out, 32'h3000_0000);
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0; bus.ad_in = 32'h1357_9BDF;
    tick(); tick(); tick();
    chk("bz_end_busy", busy, 0);
    bus_idle();
    tick(); tick();
    chk("bz_after_req", bus.req_n, 1);
    chk("bz_after_busy", busy, 0);

    // Maximum length write of 15
    repeat (15) push(K_WR, 0);
    push(K_DONE, 0);
    start_txn(1'b1, 32'h8000_0000, 4'd15, 4'hF, 32'hCAFE_0000);
    grant();
    bus.devsel_n = 1'b0; bus.trdy_n = 1'b0;
    tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("w15_d%0d_frame", i + 1), bus.frame_n, (i == 14) ? 32'd1 : 32'd0);
    end
    tick();
    chk("w15_end_busy", busy, 0);
    bus_idle();

    for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
    tick();
    chk("sb_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
